// File: rtl/ysyx_23060124_ifu.sv
// +----------------------------------------------------------------------------+
// | Module  : ysyx_23060124_ifu                                                |
// | Brief   : Instruction fetch unit; one AXI4-Lite read in flight at a time.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module ysyx_23060124_ifu #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 i_rst_ifu,
  // next PC from write-back
  input  logic [ISA_WIDTH-1:0] i_pc_next,
  input  logic                 i_pc_update,
  // AXI4-Lite read address channel
  output logic [ISA_WIDTH-1:0] o_ifu_araddr,
  output logic                 o_ifu_arvalid,
  input  logic                 i_ifu_arready,
  // AXI4-Lite read data channel
  input  logic [31:0]          i_ifu_rdata,
  input  logic [1:0]           i_ifu_rresp,
  input  logic                 i_ifu_rvalid,
  output logic                 o_ifu_rready,
  // decode-side handshake
  output logic [31:0]          o_ins,
  output logic [ISA_WIDTH-1:0] o_pc,
  output logic                 o_ins_err,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  // performance counter
  output logic [31:0]          o_fetch_cnt
);

  localparam logic [1:0] c_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ISA_WIDTH-1:0] r_araddr;
  logic [ISA_WIDTH-1:0] w_araddr_next;
  logic                 r_arvalid;
  logic                 r_rready;
  logic                 r_post_valid;
  logic [31:0]          r_ins;
  logic [31:0]          w_ins_next;
  logic [ISA_WIDTH-1:0] r_pc;
  logic [ISA_WIDTH-1:0] w_pc_next;
  logic                 r_ins_err;
  logic                 w_ins_err_next;
  logic [31:0]          r_fetch_cnt;
  logic [31:0]          w_fetch_cnt_next;
  logic                 w_misaligned;

  assign w_misaligned = (i_pc_next[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge i_rst_ifu) begin
    if (i_rst_ifu) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_next     = r_state;
    w_araddr_next    = r_araddr;
    w_ins_next       = r_ins;
    w_pc_next        = r_pc;
    w_ins_err_next   = r_ins_err;
    w_fetch_cnt_next = r_fetch_cnt;

    case (r_state)
      S_IDLE: begin
        if (i_pc_update) begin
          w_araddr_next = i_pc_next;
          if (w_misaligned) begin
            // fault is reported to decode without touching the bus
            w_state_next   = S_HOLD;
            w_ins_next     = 32'd0;
            w_pc_next      = i_pc_next;
            w_ins_err_next = 1'b1;
          end else begin
            w_state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_ifu_arready) begin
          w_state_next = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (i_ifu_rvalid) begin
          w_state_next   = S_HOLD;
          w_ins_next     = i_ifu_rdata;
          w_pc_next      = r_araddr;
          w_ins_err_next = (i_ifu_rresp != c_RESP_OKAY);
        end
      end
      S_HOLD: begin
        if (i_post_ready) begin
          w_state_next     = S_IDLE;
          w_fetch_cnt_next = r_fetch_cnt + 32'd1;
        end
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  // Handshake flags are decoded from the next state so they stay registered
  always_ff @(posedge clk or posedge i_rst_ifu) begin
    if (i_rst_ifu) begin
      r_araddr     <= RESET_PC;
      r_arvalid    <= 1'b1;
      r_rready     <= 1'b0;
      r_post_valid <= 1'b0;
      r_ins        <= 32'd0;
      r_pc         <= '0;
      r_ins_err    <= 1'b0;
      r_fetch_cnt  <= 32'd0;
    end else begin
      r_araddr     <= w_araddr_next;
      r_arvalid    <= (w_state_next == S_REQ);
      r_rready     <= (w_state_next == S_WAIT_R);
      r_post_valid <= (w_state_next == S_HOLD);
      r_ins        <= w_ins_next;
      r_pc         <= w_pc_next;
      r_ins_err    <= w_ins_err_next;
      r_fetch_cnt  <= w_fetch_cnt_next;
    end
  end

  assign o_ifu_araddr  = r_araddr;
  assign o_ifu_arvalid = r_arvalid;
  assign o_ifu_rready  = r_rready;
  assign o_post_valid  = r_post_valid;
  assign o_ins         = r_ins;
  assign o_pc          = r_pc;
  assign o_ins_err     = r_ins_err;
  assign o_fetch_cnt   = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060124_ifu.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_ysyx_23060124_ifu                                             |
// | Brief   : Scoreboard bench for the fetch unit with a delay-programmable    |
// |           AXI4-Lite read slave.                                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_23060124_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        pc_update;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        ins_err;
  logic        post_valid;
  logic        post_ready;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ysyx_23060124_ifu #(
    .ISA_WIDTH (32),
    .RESET_PC  (32'h8000_0000)
  ) dut (
    .clk           (clk),
    .i_rst_ifu     (rst),
    .i_pc_next     (pc_next),
    .i_pc_update   (pc_update),
    .o_ifu_araddr  (araddr),
    .o_ifu_arvalid (arvalid),
    .i_ifu_arready (arready),
    .i_ifu_rdata   (rdata),
    .i_ifu_rresp   (rresp),
    .i_ifu_rvalid  (rvalid),
    .o_ifu_rready  (rready),
    .o_ins         (ins),
    .o_pc          (pc),
    .o_ins_err     (ins_err),
    .o_post_valid  (post_valid),
    .i_post_ready  (post_ready),
    .o_fetch_cnt   (fetch_cnt)
  );

  // ---------------- slave model ----------------
  int          ar_delay;
  int          r_delay;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_rresp;
  logic        flush;
  int          ar_cnt = 0;
  int          r_cnt  = 0;
  logic        r_pend = 1'b0;

  assign rdata = cfg_rdata;
  assign rresp = cfg_rresp;

  always @(posedge clk) begin
    if (arvalid && arready) begin
      r_pend <= 1'b1;
      r_cnt  <= 0;
      ar_cnt <= 0;
    end else begin
      if (arvalid) ar_cnt <= ar_cnt + 1;
      if (flush)                  r_pend <= 1'b0;
      else if (rvalid && rready)  r_pend <= 1'b0;
      else if (r_pend)            r_cnt  <= r_cnt + 1;
    end
  end

  always @(negedge clk) begin
    arready = arvalid && (ar_cnt >= ar_delay);
    rvalid  = r_pend && (r_cnt >= r_delay);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic seen = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits for post_valid; while the AR phase is pending it checks address hold
  task automatic wait_valid(input int lim, input logic [31:0] exp_addr, output int n);
    n = 0;
    while (n < lim) begin
      @(posedge clk); #1;
      n++;
      if (post_valid) return;
      if (arvalid) begin
        chk("araddr_stable", araddr, exp_addr);
        chk("rready_during_ar", {31'd0, rready}, 32'd0);
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_valid: got no post_valid in %0d cycles, expected post_valid=1", lim);
  endtask

  // Accepts the held instruction; upd/nxt are presented for the following IDLE edge
  task automatic accept(input logic upd, input logic [31:0] nxt, input logic [31:0] exp_cnt);
    @(negedge clk); #1;
    post_ready = 1'b1;
    pc_update  = upd;
    pc_next    = nxt;
    @(posedge clk); #1;
    post_ready = 1'b0;
    chk("fetch_cnt", fetch_cnt, exp_cnt);
    chk("post_valid_drop", {31'd0, post_valid}, 32'd0);
    @(posedge clk); #1;
    pc_update = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_araddr",  araddr,               32'h8000_0000);
    chk("rst_arvalid", {31'd0, arvalid},     32'd1);
    chk("rst_rready",  {31'd0, rready},      32'd0);
    chk("rst_pvalid",  {31'd0, post_valid},  32'd0);
    chk("rst_ins",     ins,                  32'd0);
    chk("rst_pc",      pc,                   32'd0);
    chk("rst_err",     {31'd0, ins_err},     32'd0);
    chk("rst_cnt",     fetch_cnt,            32'd0);
  endtask

  int   n;
  logic saw_stale;

  initial begin
    rst        = 1'b0;
    pc_next    = 32'd0;
    pc_update  = 1'b0;
    post_ready = 1'b0;
    ar_delay   = 0;
    r_delay    = 0;
    cfg_rdata  = 32'h0000_0413;
    cfg_rresp  = 2'b00;
    flush      = 1'b0;

    // monitor: pops on each new presentation, then checks stability while held
    fork
      forever begin
        @(negedge clk);
        if (!post_valid) begin
          seen = 1'b0;
        end else if (!seen) begin
          seen = 1'b1;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got ins %h pc %h, expected no output", ins, pc);
            cur = '0;
          end else begin
            cur = q.pop_front();
            chk("sb_ins", ins, cur.ins);
            chk("sb_pc",  pc,  cur.pc);
            chk("sb_err", {31'd0, ins_err}, {31'd0, cur.err});
          end
        end else begin
          chk("hold_ins", ins, cur.ins);
          chk("hold_pc",  pc,  cur.pc);
          chk("hold_err", {31'd0, ins_err}, {31'd0, cur.err});
        end
      end
    join_none

    #1 rst = 1'b1;
    #2 chk_reset_vals();

    // first fetch out of reset: AR at edge 1, R at edge 2
    q.push_back('{ins: 32'h0000_0413, pc: 32'h8000_0000, err: 1'b0});
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("f1_rready",  {31'd0, rready},     32'd1);
    chk("f1_arvalid", {31'd0, arvalid},    32'd0);
    chk("f1_pvalid0", {31'd0, post_valid}, 32'd0);
    @(posedge clk); #1;
    chk("f1_pvalid1", {31'd0, post_valid}, 32'd1);

    // decode stall of 5 cycles; next fetch uses bus back-pressure 3/4
    repeat (5) @(negedge clk);
    #1;
    ar_delay  = 3;
    r_delay   = 4;
    cfg_rdata = 32'h0010_0093;
    accept(1'b1, 32'h8000_0004, 32'd1);
    chk("f2_araddr",  araddr,            32'h8000_0004);
    chk("f2_arvalid", {31'd0, arvalid},  32'd1);
    q.push_back('{ins: 32'h0010_0093, pc: 32'h8000_0004, err: 1'b0});
    wait_valid(30, 32'h8000_0004, n);
    chk("f2_latency", n, 32'd9);

    // misaligned PC: no bus request, fault presented right away
    ar_delay = 0;
    r_delay  = 0;
    q.push_back('{ins: 32'd0, pc: 32'h8000_0006, err: 1'b1});
    accept(1'b1, 32'h8000_0006, 32'd2);
    chk("mis_pvalid",  {31'd0, post_valid}, 32'd1);
    chk("mis_arvalid", {31'd0, arvalid},    32'd0);

    // error response still delivers rdata and counts on accept
    cfg_rdata = 32'hDEAD_BEEF;
    cfg_rresp = 2'b10;
    q.push_back('{ins: 32'hDEAD_BEEF, pc: 32'h8000_0008, err: 1'b1});
    accept(1'b1, 32'h8000_0008, 32'd3);
    chk("e_araddr", araddr, 32'h8000_0008);
    wait_valid(20, 32'h8000_0008, n);
    chk("e_latency", n, 32'd2);
    accept(1'b0, 32'd0, 32'd4);

    // asynchronous reset while waiting on R
    cfg_rresp = 2'b00;
    cfg_rdata = 32'h0000_0513;
    r_delay   = 3;
    @(negedge clk); #1;
    pc_update = 1'b1;
    pc_next   = 32'h8000_000C;
    @(posedge clk); #1;
    pc_update = 1'b0;
    @(posedge clk); #1;
    chk("r_wait_rready", {31'd0, rready}, 32'd1);
    @(negedge clk); #2;
    ar_delay = 1000;
    rst      = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk); #1 rst = 1'b0;
    saw_stale = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      saw_stale = saw_stale | rvalid;
      chk("stale_pvalid",  {31'd0, post_valid}, 32'd0);
      chk("stale_rready",  {31'd0, rready},     32'd0);
      chk("stale_arvalid", {31'd0, arvalid},    32'd1);
    end
    chk("stale_seen", {31'd0, saw_stale}, 32'd1);
    @(negedge clk); #1;
    flush    = 1'b1;
    ar_delay = 0;
    r_delay  = 0;
    q.push_back('{ins: 32'h0000_0513, pc: 32'h8000_0000, err: 1'b0});
    @(negedge clk); #1 flush = 1'b0;
    wait_valid(20, 32'h8000_0000, n);
    accept(1'b0, 32'd0, 32'd1);

    chk("sb_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
